// File: rtl/dct_coeff_accum.sv
// dct_coeff_accum: accumulates one 2-D DCT coefficient over an 8x8 pixel block.
// Pixels arrive in raster order. idx drives the cosine LUT address
// (n1 = row, n2 = column), and the LUT returns cos_term in the same cycle.
// Each product is registered for one cycle before it is added to acc, so the
// multiplier and the adder sit in separate pipeline stages.
module dct_coeff_accum #(
    parameter int PIX_W    = 8,
    parameter int ACC_W    = 32,
    parameter int ALPHA_Q8 = 45,
    parameter int COEF_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         pixel,
    output logic [2:0]               n1,
    output logic [2:0]               n2,
    input  logic signed [31:0]       cos_term,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [COEF_W-1:0] coef
);

    localparam int T_W = ACC_W + 8;
    localparam logic signed [T_W-1:0] RND_HALF = T_W'(64'sd1 <<< 15);
    localparam logic signed [T_W-1:0] COEF_MAX = T_W'((64'sd1 <<< (COEF_W - 1)) - 64'sd1);
    localparam logic signed [T_W-1:0] COEF_MIN = T_W'(-(64'sd1 <<< (COEF_W - 1)));

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                     state_r;
    state_t                     state_s;
    logic [5:0]                 idx_r;
    logic signed [ACC_W-1:0]    acc_r;
    logic signed [ACC_W-1:0]    prod_r;
    logic                       prod_v_r;
    logic signed [COEF_W-1:0]   coef_r;

    logic                       hs_s;
    logic signed [PIX_W:0]      px_s;
    logic signed [ACC_W-1:0]    mul_s;
    logic signed [ACC_W-1:0]    acc_add_s;
    logic signed [T_W-1:0]      t_s;
    logic signed [T_W-1:0]      shr_s;
    logic signed [COEF_W-1:0]   sat_s;

    // Clamp a scaled value into the signed COEF_W output range.
    function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [T_W-1:0] v);
        logic signed [COEF_W-1:0] r;
        if (v > COEF_MAX) begin
            r = {1'b0, {(COEF_W-1){1'b1}}};
        end else if (v < COEF_MIN) begin
            r = {1'b1, {(COEF_W-1){1'b0}}};
        end else begin
            r = v[COEF_W-1:0];
        end
        return r;
    endfunction

    assign hs_s      = in_valid && (state_r == ACCUM);
    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == DONE);
    assign n1        = idx_r[5:3];
    assign n2        = idx_r[2:0];
    assign coef      = coef_r;

    // Datapath arithmetic: level shift and multiply, pending-product gating, and Q8 scaling with half-up rounding.
    always_comb begin
        px_s      = $signed({1'b0, pixel}) - $signed((PIX_W+1)'(2 ** (PIX_W - 1)));
        mul_s     = ACC_W'(ACC_W'(px_s) * ACC_W'(cos_term));
        acc_add_s = prod_v_r ? prod_r : '0;
        t_s       = T_W'(acc_r) * T_W'(ALPHA_Q8);
        shr_s     = (t_s + RND_HALF) >>> 6'd16;
        sat_s     = sat_coef(shr_s);
    end

    // Block sequencing: accumulate 64 samples, drain the last product, scale, then hold until the coefficient is taken.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ACCUM: begin
                if (hs_s && (idx_r == 6'd63)) begin
                    state_s = DRAIN;
                end else begin
                    state_s = ACCUM;
                end
            end
            DRAIN:   state_s = SCALE;
            SCALE:   state_s = DONE;
            DONE: begin
                if (out_ready) begin
                    state_s = ACCUM;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = ACCUM;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath registers. A pending product is added exactly once, on the cycle after it is formed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_r    <= 6'd0;
            acc_r    <= '0;
            prod_r   <= '0;
            prod_v_r <= 1'b0;
            coef_r   <= '0;
        end else begin
            case (state_r)
                ACCUM: begin
                    acc_r    <= acc_r + acc_add_s;
                    prod_v_r <= hs_s;
                    if (hs_s) begin
                        prod_r <= mul_s;
                        idx_r  <= idx_r + 6'd1;
                    end
                end
                DRAIN: begin
                    acc_r    <= acc_r + acc_add_s;
                    prod_v_r <= 1'b0;
                end
                SCALE: begin
                    coef_r   <= sat_s;
                    acc_r    <= '0;
                    prod_v_r <= 1'b0;
                end
                DONE: begin
                    coef_r <= coef_r;
                end
                default: begin
                    acc_r    <= '0;
                    prod_v_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dct_coeff_accum.sv
// Self-checking bench for dct_coeff_accum: directed blocks plus randomized pixels,
// gaps and LUT contents, checked against an arithmetic reference model.
module tb_dct_coeff_accum;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [7:0]         pixel;
    logic [2:0]         n1;
    logic [2:0]         n2;
    logic signed [31:0] cos_term;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] coef;

    int nchk = 0;
    int nerr = 0;
    int pix [64];
    int lut [64];
    int cos6 [8] = '{98, -236, 236, -98, -98, 236, -236, 98};
    logic [15:0] got_a;
    logic [15:0] got_b;

    dct_coeff_accum #(.PIX_W(8), .ACC_W(32), .ALPHA_Q8(45), .COEF_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pixel(pixel), .n1(n1), .n2(n2), .cos_term(cos_term),
        .out_valid(out_valid), .out_ready(out_ready), .coef(coef)
    );

    // LUT responds combinationally to the requested (n1, n2).
    assign cos_term = lut[{n1, n2}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: sum of level-shifted pixels times LUT values (32-bit wrap), scaled by 45/65536 with half-up rounding, clamped.
    function automatic logic [15:0] model();
        int acc = 0;
        longint t;
        longint r;
        for (int i = 0; i < 64; i++) acc += (pix[i] - 128) * lut[i];
        t = longint'(acc) * 64'sd45;
        r = (t + 64'sd32768) >>> 16;
        if (r > 64'sd32767) r = 64'sd32767;
        if (r < -64'sd32768) r = -64'sd32768;
        return 16'(r);
    endfunction

    task automatic load_k6();
        for (int i = 0; i < 64; i++) lut[i] = cos6[i % 8];
    endtask

    // Present one block with random idle gaps, collect the coefficient, then hold out_ready low for 'stall' cycles.
    task automatic run_block(input int gap_pct, input int stall, input bit chk_lat, output logic [15:0] got);
        bit seen;
        for (int i = 0; i < 64; i++) begin
            while (int'($urandom_range(0, 99)) < gap_pct) begin
                in_valid = 1'b0;
                pixel    = 8'($urandom);
                tick();
            end
            in_valid = 1'b1;
            pixel    = 8'(pix[i]);
            chk("idx", {26'd0, n1, n2}, 32'(i));
            tick();
        end
        in_valid = 1'b0;
        if (chk_lat) begin
            chk("drain_rdy", {31'd0, in_ready}, 32'd0);
            chk("drain_ov", {31'd0, out_valid}, 32'd0);
            tick();
            chk("scale_ov", {31'd0, out_valid}, 32'd0);
            tick();
            chk("done_ov_e2", {31'd0, out_valid}, 32'd1);
            chk("done_rdy", {31'd0, in_ready}, 32'd0);
        end else begin
            seen = 1'b0;
            for (int c = 0; c < 8; c++) begin
                if (out_valid) begin
                    seen = 1'b1;
                    break;
                end
                tick();
            end
            chk("ov_timeout", {31'd0, seen}, 32'd1);
        end
        got = coef;
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            pixel    = 8'($urandom);
            tick();
            chk("stall_ov", {31'd0, out_valid}, 32'd1);
            chk("stall_rdy", {31'd0, in_ready}, 32'd0);
            chk("stall_coef", {16'd0, coef}, {16'd0, got});
            chk("stall_idx", {26'd0, n1, n2}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_ov", {31'd0, out_valid}, 32'd0);
        chk("post_rdy", {31'd0, in_ready}, 32'd1);
        chk("post_idx", {26'd0, n1, n2}, 32'd0);
    endtask

    initial begin
        logic [15:0] g;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pixel     = 8'd0;
        load_k6();
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_ov", {31'd0, out_valid}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("rst_idx", {26'd0, n1, n2}, 32'd0);
        chk("rst_coef", {16'd0, coef}, 32'd0);

        // Constant mid-grey block
        for (int i = 0; i < 64; i++) pix[i] = 128;
        run_block(0, 0, 1'b1, g);
        chk("const128", {16'd0, g}, 32'd0);

        // All-white block: cosine terms cancel per row
        for (int i = 0; i < 64; i++) pix[i] = 255;
        run_block(0, 0, 1'b1, g);
        chk("const255", {16'd0, g}, 32'd0);

        // Alternating column pattern matched to the k2=6 signs
        for (int i = 0; i < 64; i++) pix[i] = ((i % 8) inside {0, 2, 5, 7}) ? 228 : 28;
        run_block(0, 0, 1'b1, g);
        chk("colpat", {16'd0, g}, 32'h0000_02DE);

        // Single impulse at (0,1)
        for (int i = 0; i < 64; i++) pix[i] = 128;
        pix[1] = 255;
        run_block(0, 0, 1'b1, g);
        chk("impulse", {16'd0, g}, {16'd0, 16'hFFEB});

        // Random pixels: gap-free reference run, then the same block with gaps and a DONE stall
        for (int i = 0; i < 64; i++) pix[i] = int'($urandom_range(0, 255));
        run_block(0, 0, 1'b0, got_a);
        chk("rand_model", {16'd0, got_a}, {16'd0, model()});
        run_block(40, 10, 1'b0, got_b);
        chk("gap_eq_nogap", {16'd0, got_b}, {16'd0, got_a});

        // Positive and negative saturation
        for (int i = 0; i < 64; i++) begin
            lut[i] = 200000;
            pix[i] = 255;
        end
        run_block(0, 0, 1'b0, g);
        chk("sat_pos", {16'd0, g}, 32'h0000_7FFF);
        for (int i = 0; i < 64; i++) pix[i] = 0;
        run_block(0, 0, 1'b0, g);
        chk("sat_neg", {16'd0, g}, 32'h0000_8000);

        // Random LUT contents, mixed magnitudes (including wrap-around), with gaps
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 64; i++) begin
                pix[i] = int'($urandom_range(0, 255));
                lut[i] = (b < 2) ? (int'($urandom_range(0, 60000)) - 30000) : int'($urandom);
            end
            run_block(30, b, 1'b0, g);
            chk("rand_lut", {16'd0, g}, {16'd0, model()});
        end

        // Reset in the middle of a block discards the partial sum
        load_k6();
        for (int i = 0; i < 40; i++) begin
            in_valid = 1'b1;
            pixel    = 8'($urandom_range(0, 255));
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mid_rst_idx", {26'd0, n1, n2}, 32'd0);
        chk("mid_rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_ov", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_coef", {16'd0, coef}, 32'd0);
        for (int i = 0; i < 64; i++) pix[i] = 128;
        run_block(0, 0, 1'b1, g);
        chk("after_rst", {16'd0, g}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
